// File: rtl/riscv_pkg.sv
// Shared RV64M multiply definitions: funct3 op codes, FSM states, size constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned XLEN_RV64 = 64;

  // Number of BUSY cycles needed to consume the multiplier magnitude.
  function automatic int unsigned mul_iters(input int unsigned width,
                                            input int unsigned bpc,
                                            input bit          dsp);
    return dsp ? 1 : width / bpc;
  endfunction

endpackage

// File: rtl/rv_mul_step.sv
// Combinational shift-add step: accumulates multiplicand x STEP multiplier bits.
module rv_mul_step #(
  parameter int unsigned ACC_W = 128,
  parameter int unsigned STEP  = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_mcand,
  input  logic [STEP-1:0]  i_bits,
  output logic [ACC_W-1:0] o_acc
);

  // The multiplicand is pre-shifted by the caller, so the partial product never overflows ACC_W.
  assign o_acc = i_acc + (i_mcand * ACC_W'(i_bits));

endmodule

// File: rtl/rv_mul_unit.sv
// Iterative RV64M multiply unit (MUL/MULH/MULHSU/MULHU/MULW) with valid/ready and flush.
module rv_mul_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 8,
  parameter bit          USE_DSP        = 1'b0,
  parameter int unsigned TAG_W          = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned ACC_W  = 2 * XLEN;
  localparam int unsigned STEP   = USE_DSP ? XLEN : BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(XLEN) + 1;
  localparam int unsigned N_FULL = mul_iters(XLEN, BITS_PER_CYCLE, USE_DSP);
  localparam int unsigned N_WORD = mul_iters(WORD_W, BITS_PER_CYCLE, USE_DSP);
  localparam bit          WORD_OK = (XLEN == XLEN_RV64);

  mul_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_hi;
  logic             r_word;
  logic [TAG_W-1:0] r_tag;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_word;
  logic             w_a_sgn;
  logic             w_b_sgn;
  logic             w_hi;
  logic [XLEN-1:0]  w_a_ext;
  logic [XLEN-1:0]  w_b_ext;
  logic [XLEN-1:0]  w_a_mag;
  logic [XLEN-1:0]  w_b_mag;
  logic             w_accept;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_prod;
  logic [XLEN-1:0]  w_result;

  // Operand decode: word mode forces signed 32-bit MUL semantics.
  assign w_word  = in_word & WORD_OK;
  assign w_a_ext = w_word ? XLEN'($signed(in_a[WORD_W-1:0])) : in_a;
  assign w_b_ext = w_word ? XLEN'($signed(in_b[WORD_W-1:0])) : in_b;
  assign w_a_sgn = w_word ? in_a[WORD_W-1]
                          : (((in_op == OP_MULH) | (in_op == OP_MULHSU)) & in_a[XLEN-1]);
  assign w_b_sgn = w_word ? in_b[WORD_W-1] : ((in_op == OP_MULH) & in_b[XLEN-1]);
  assign w_hi    = ~w_word & ((in_op == OP_MULH) | (in_op == OP_MULHSU) | (in_op == OP_MULHU));
  // Two's-complement negation yields the exact magnitude 2^(XLEN-1) for the most-negative value.
  assign w_a_mag = w_a_sgn ? (~w_a_ext + XLEN'(1)) : w_a_ext;
  assign w_b_mag = w_b_sgn ? (~w_b_ext + XLEN'(1)) : w_b_ext;

  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept = in_valid & in_ready & ~flush;

  rv_mul_step #(
    .ACC_W (ACC_W),
    .STEP  (STEP)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bits  (r_mplier[STEP-1:0]),
    .o_acc   (w_acc_nxt)
  );

  // Finalize: restore sign on the full product, then pick the requested half.
  assign w_prod   = r_neg ? (~r_acc + ACC_W'(1)) : r_acc;
  assign w_result = r_word ? XLEN'($signed(w_prod[WORD_W-1:0]))
                  : r_hi   ? w_prod[ACC_W-1:XLEN]
                           : w_prod[XLEN-1:0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_hi         <= 1'b0;
      r_word       <= 1'b0;
      r_tag        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= BUSY;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= ACC_W'(w_a_mag);
      r_mplier    <= w_b_mag;
      r_cnt       <= w_word ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
      r_neg       <= w_a_sgn ^ w_b_sgn;
      r_hi        <= w_hi;
      r_word      <= w_word;
      r_tag       <= in_tag;
    end else begin
      case (r_state)
        BUSY: begin
          if (r_cnt != '0) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << STEP;
            r_mplier <= r_mplier >> STEP;
            r_cnt    <= r_cnt - CNT_W'(1);
          end else begin
            r_out_result <= w_result;
            r_out_tag    <= r_tag;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_rv_mul_unit.sv
// Bench for rv_mul_unit: iterative (BPC=8) and single-step DSP instances against a wide-arithmetic model.
module tb_rv_mul_unit;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        flush;
  logic        in_valid, d_in_valid;
  logic        out_ready, d_out_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        in_ready, d_in_ready;
  logic        out_valid, d_out_valid;
  logic [63:0] out_result, d_out_result;
  logic [4:0]  out_tag, d_out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_mul_unit #(.XLEN(64), .BITS_PER_CYCLE(8), .USE_DSP(1'b0), .TAG_W(5)) u_dut (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  rv_mul_unit #(.XLEN(64), .BITS_PER_CYCLE(8), .USE_DSP(1'b1), .TAG_W(5)) u_dsp (
    .clk(clk), .n_reset(n_reset), .flush(flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(in_op), .in_word(in_word),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_result(d_out_result), .out_tag(d_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed/unsigned product in 130-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    longint sa, sb, pw;
    if (w) begin
      sa = $signed(a[31:0]);
      sb = $signed(b[31:0]);
      pw = sa * sb;
      return {{32{pw[31]}}, pw[31:0]};
    end
    ea = (op == 3'd1 || op == 3'd2) ? {{66{a[63]}}, a} : {66'd0, a};
    eb = (op == 3'd1) ? {{66{b[63]}}, b} : {66'd0, b};
    p  = ea * eb;
    if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[127:64];
    return p[63:0];
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'd0, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op to both units with out_ready=1; check result, tag and latency of each.
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input string name);
    logic [63:0] exp;
    int lat_m, lat_d;
    bit seen_m, seen_d;
    exp = ref_mul(op, w, a, b);
    lat_m = 0; lat_d = 0; seen_m = 0; seen_d = 0;
    in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tag;
    in_valid = 1'b1; d_in_valid = 1'b1;
    chk({name, ".rdy"}, {62'd0, in_ready, d_in_ready}, 64'd3);
    @(posedge clk); #1;
    in_valid = 1'b0; d_in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_tag = 5'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (!seen_m && out_valid) begin
        seen_m = 1; lat_m = k;
        chk({name, ".res"}, out_result, exp);
        chk({name, ".tag"}, 64'(out_tag), 64'(tag));
      end
      if (!seen_d && d_out_valid) begin
        seen_d = 1; lat_d = k;
        chk({name, ".dsp_res"}, d_out_result, exp);
        chk({name, ".dsp_tag"}, 64'(d_out_tag), 64'(tag));
      end
      if (seen_m && seen_d) break;
    end
    chk({name, ".lat"}, 64'(lat_m), w ? 64'd5 : 64'd9);
    chk({name, ".dsp_lat"}, 64'(lat_d), 64'd2);
  endtask

  // Wait for the iterative unit's out_valid, returning edges elapsed (0 on timeout).
  task automatic wait_main(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit leak;
    logic [2:0] op;
    logic w;

    n_reset = 1'b0; flush = 1'b0; in_valid = 1'b0; d_in_valid = 1'b0;
    out_ready = 1'b1; d_out_ready = 1'b1;
    in_op = 3'd0; in_word = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {62'd0, in_ready, d_in_ready}, 64'd3);
    chk("rst.out_valid", {62'd0, out_valid, d_out_valid}, 64'd0);
    chk("rst.out_result", out_result, 64'd0);
    chk("rst.out_tag", 64'(out_tag), 64'd0);
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
    run_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd17, "mul_3x5");
    run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, "mulh_m1");
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, "mulhu_m1");
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, "mulhsu_m1");
    run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, "mulh_min");
    run_op(3'd1, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd5, "mulw_max");
    run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd6, "op_other");

    // Randomised ops with corner-biased operands
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      run_op(op, w, pick_operand(), pick_operand(), 5'($urandom), $sformatf("rnd%0d", i));
    end

    // Backpressure on the iterative unit, then same-edge back-to-back accept
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_op = 3'd0; in_word = 1'b0; in_a = 64'd11; in_b = 64'd13; in_tag = 5'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_main(lat);
    chk("bp.lat", 64'(lat), 64'd9);
    in_a = 64'd100; in_b = 64'd200; in_tag = 5'd3; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp.hold_ready", {63'd0, in_ready}, 64'd0);
      chk("bp.hold_res", out_result, 64'd143);
      chk("bp.hold_tag", 64'(out_tag), 64'd9);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.b2b_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("bp.b2b_busy", {63'd0, in_ready}, 64'd0);
    wait_main(lat);
    chk("bp.b2b_lat", 64'(lat), 64'd9);
    chk("bp.b2b_res", out_result, 64'd20000);
    chk("bp.b2b_tag", 64'(out_tag), 64'd3);
    @(posedge clk); #1;

    // Flush on the third BUSY cycle, with a competing request in the same cycle
    in_op = 3'd0; in_a = 64'd123; in_b = 64'd456; in_tag = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_a = 64'd9; in_b = 64'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush.idle", {63'd0, in_ready}, 64'd1);
    chk("flush.res_kept", out_result, 64'd20000);
    leak = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) leak = 1;
    end
    chk("flush.no_valid", {63'd0, leak}, 64'd0);
    run_op(3'd0, 1'b0, 64'd7, 64'd6, 5'd11, "post_flush");

    // Asynchronous reset pulse in the middle of BUSY
    in_op = 3'd3; in_word = 1'b0; in_a = 64'hDEAD_BEEF_0000_1234; in_b = 64'h55;
    in_tag = 5'd21; in_valid = 1'b1; d_in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; d_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("areset.out_valid", {62'd0, out_valid, d_out_valid}, 64'd0);
    chk("areset.out_result", out_result, 64'd0);
    chk("areset.out_tag", 64'(out_tag), 64'd0);
    chk("areset.in_ready", {62'd0, in_ready, d_in_ready}, 64'd3);
    #2;
    n_reset = 1'b1;
    leak = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid || d_out_valid) leak = 1;
    end
    chk("areset.no_valid", {63'd0, leak}, 64'd0);
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd30, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_mul_unit.md
Name: rv_mul_unit

Overview:
- Iterative, parametrised RV64M multiply unit for the execute stage.
- Executes MUL, MULH, MULHSU, MULHU and MULW.
- Retires BITS_PER_CYCLE multiplier bits per cycle, or the full product in one step when USE_DSP=1.
- Valid/ready handshakes on both sides, plus a pipeline flush.

Parameters:
- XLEN, 64, operand/result width; 32 or 64 only.
- BITS_PER_CYCLE, 8, multiplier bits consumed per BUSY cycle; power of two, 1..32.
- USE_DSP, 0, 1 = single BUSY cycle using a full-width multiplier.
- TAG_W, 5, width of the pass-through destination tag.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any in-flight or completed op
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; others behave as MUL
- in_word  in  1  MULW (RV64 only): low 32 bits, result sign-extended
- in_a  in  XLEN  rs1
- in_b  in  XLEN  rs2
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Clock and reset: single clock clk. n_reset is asynchronous and active-low.
- Reset state: IDLE. in_ready=1, out_valid=0, out_result=0, out_tag=0, accumulators cleared.
- Reset mid-operation: the operation is lost and no output is produced.
- States: IDLE, BUSY, DONE.
  - in_ready = (IDLE) or (DONE and out_ready).
  - Accept = in_valid and in_ready.
- On accept, latch the following, then go to BUSY:
  - operand magnitudes: signed for rs1 on MULH/MULHSU, signed for rs2 on MULH;
  - result sign = XOR of the operand signs;
  - half select = op != MUL;
  - tag.
- Word mode:
  - uses in_a[31:0] and in_b[31:0] as signed;
  - always MUL semantics regardless of in_op.
- Iteration count N:
  - XLEN/BITS_PER_CYCLE, or 32/BITS_PER_CYCLE in word mode;
  - N=1 when USE_DSP=1.
- BUSY cycle: add (multiplicand × next BITS_PER_CYCLE multiplier bits), shifted, into a 2·XLEN accumulator. Decrement the counter.
- After the N-th BUSY edge, a finalize edge:
  - negate the 2·XLEN product if sign=1;
  - select high (MULH*) or low half;
  - for word mode, sign-extend bit 31;
  - register into out_result and go to DONE.
- Latency: out_valid rises N+1 edges after the accept edge.
  - 64-bit, BITS_PER_CYCLE=8: 9 edges.
  - MULW: 5 edges.
  - USE_DSP=1: 2 edges.
- DONE: out_valid=1. out_result and out_tag are held stable while out_ready=0.
- Completion in DONE with out_ready=1:
  - in_valid=1: back-to-back accept, go to BUSY; out_valid drops next edge.
  - in_valid=0: go to IDLE.
- flush has highest priority:
  - next edge goes to IDLE, out_valid=0;
  - a same-cycle in_valid is not accepted (in_ready is still driven per state, but the accept is suppressed);
  - out_result keeps its last value.
- Arithmetic:
  - unsigned magnitude multiply, full 2·XLEN product, no truncation before selection;
  - most-negative operand magnitudes (2^(XLEN-1)) must be handled exactly.
- Inputs are sampled only on the accept edge; operand changes during BUSY are ignored.

Decomposition:
- riscv_pkg (shared): mul_op_t enum matching the funct3 codes; mul_state_t {IDLE, BUSY, DONE}; XLEN-derived localparams.
- One sub-module, rv_mul_step: combinational partial-product add of BITS_PER_CYCLE bits into the accumulator. The top holds the FSM, counter, sign/negation and handshakes.

Test Plan:
- MUL a=3, b=5, out_ready=1 → out_valid 9 edges after accept, result 0x000000000000000F, tag echoed.
- MULH a=b=0xFFFF_FFFF_FFFF_FFFF → result 0. MULHU same operands → 0xFFFF_FFFF_FFFF_FFFE. MULHSU same operands → 0xFFFF_FFFF_FFFF_FFFF.
- MULW a=0x7FFF_FFFF, b=2 → result 0xFFFF_FFFF_FFFF_FFFE after 5 edges. MULH a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 → result and tag stable, in_ready=0, no accept. Release with in_valid=1 → back-to-back accept on the same edge.
- flush asserted on the 3rd BUSY cycle → IDLE next edge, out_valid never rises. The next op (7×6) returns 42 with normal latency.
- n_reset pulsed low mid-BUSY (asynchronous, between edges) → outputs are 0 and in_ready=1 immediately. Repeat the MUL/MULHU cases with USE_DSP=1 → 2-edge latency, identical results.
